bypass_eq_slt_serial_unit: RTL and testbench

//  Parametrised sequential successor of the 4-bit bypass/equality/SLT operation group.
//  - Accepts an operand pair over a valid/ready handshake.
//  - Compares A and B MSB-first, DIGIT bits per cycle; signed or unsigned per transaction.
//  - Presents bypass A, bypass B, zero-extended EQ and zero-extended SLT on a registered, backpressured output.
//  - Sits in the ALSU operation bank alongside the other modular operation units.

---
 rtl/bypass_eq_slt_serial_unit.sv | 141 ++++++++++++++
 tb/tb_bypass_eq_slt_serial_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bypass_eq_slt_serial_unit.sv
// Serial MSB-first equality / set-less-than unit with operand bypass and a backpressured result.
// Optional build macro BESLT_EARLY_EXIT_EN: finish the scan on the first differing digit.
module bypass_eq_slt_serial_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_a_o,
  output logic [WIDTH-1:0] out_b_o,
  output logic [WIDTH-1:0] out_eq_o,
  output logic [WIDTH-1:0] out_slt_o
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0]   cmp_b_q, cmp_b_d;
  logic [WIDTH-1:0]   out_a_q, out_a_d;
  logic [WIDTH-1:0]   out_b_q, out_b_d;
  logic               lt_q, lt_d;
  logic               decided_q, decided_d;
  logic               eq_q, eq_d;
  logic               slt_q, slt_d;

  logic [DIGIT-1:0]   dig_a, dig_b;
  logic               digit_diff;
  logic               scan_done;

  // Compare operands are shifted left each step, so the active digit is always on top.
  assign dig_a      = cmp_a_q[WIDTH-1 -: DIGIT];
  assign dig_b      = cmp_b_q[WIDTH-1 -: DIGIT];
  assign digit_diff = (dig_a != dig_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      lt_q      <= 1'b0;
      decided_q <= 1'b0;
      eq_q      <= 1'b0;
      slt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      lt_q      <= lt_d;
      decided_q <= decided_d;
      eq_q      <= eq_d;
      slt_q     <= slt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmp_a_d   = cmp_a_q;
    cmp_b_d   = cmp_b_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    lt_d      = lt_q;
    decided_d = decided_q;
    eq_d      = eq_q;
    slt_d     = slt_q;
    scan_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          // Flipping the sign bit turns a signed compare into an unsigned one.
          cmp_a_d   = a_i ^ {signed_mode_i, {(WIDTH-1){1'b0}}};
          cmp_b_d   = b_i ^ {signed_mode_i, {(WIDTH-1){1'b0}}};
          out_a_d   = a_i;
          out_b_d   = b_i;
          lt_d      = 1'b0;
          decided_d = 1'b0;
          cnt_d     = CNT_W'(N - 1);
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!decided_q && digit_diff) begin
          decided_d = 1'b1;
          lt_d      = (dig_a < dig_b);
        end
        cmp_a_d = cmp_a_q << DIGIT;
        cmp_b_d = cmp_b_q << DIGIT;
        cnt_d   = cnt_q - CNT_W'(1);
`ifdef BESLT_EARLY_EXIT_EN
        scan_done = (cnt_q == '0) || (!decided_q && digit_diff);
`else
        scan_done = (cnt_q == '0);
`endif
        if (scan_done) begin
          eq_d    = !decided_d;
          slt_d   = lt_d;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_HOLD);
  assign out_a_o     = out_a_q;
  assign out_b_o     = out_b_q;
  assign out_eq_o    = {{(WIDTH-1){1'b0}}, eq_q};
  assign out_slt_o   = {{(WIDTH-1){1'b0}}, slt_q};

endmodule

// File: tb/tb_bypass_eq_slt_serial_unit.sv
// Scoreboard bench for bypass_eq_slt_serial_unit: directed cases, backpressure, mid-scan reset, random traffic.
module tb_bypass_eq_slt_serial_unit;

  localparam int unsigned W = 8;
  localparam int unsigned D = 2;
  localparam int unsigned N = W / D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_b, out_eq, out_slt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] slt;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  bypass_eq_slt_serial_unit #(.WIDTH(W), .DIGIT(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .a_i           (a),
    .b_i           (b),
    .signed_mode_i (signed_mode),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_a_o       (out_a),
    .out_b_o       (out_b),
    .out_eq_o      (out_eq),
    .out_slt_o     (out_slt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain comparison arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic s);
    exp_t e;
    logic lt;
    int j;
    logic [W-1:0] x;
    lt = s ? ($signed(ma) < $signed(mb)) : (ma < mb);
    e.a   = ma;
    e.b   = mb;
    e.eq  = W'(ma == mb);
    e.slt = W'(lt);
    // Latency: number of equal leading digits decides early exit timing.
    x = ma ^ mb;
    j = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (x[W-1 -: D] != '0) break;
      j++;
      x = x << D;
    end
`ifdef BESLT_EARLY_EXIT_EN
    e.lat = (j == int'(N)) ? int'(N) : j + 1;
`else
    e.lat = int'(N);
`endif
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compare each new result against the oldest expected entry.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_a",   32'(out_a),   32'(e.a));
        check("out_b",   32'(out_b),   32'(e.b));
        check("out_eq",  32'(out_eq),  32'(e.eq));
        check("out_slt", 32'(out_slt), 32'(e.slt));
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev_ov = out_valid;
  end

  // Issue one transaction, wait for its result, hold it for 'hold' cycles, then drain.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic s, input int hold);
    exp_t e;
    int wait_cnt;
    e = model(ta, tb_, s);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb_; signed_mode = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    e.acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; signed_mode = $urandom;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 4 * int'(N) + 4) begin
      @(negedge clk);
      if (!out_valid) check("in_ready_busy", 32'(in_ready), 32'd0);
      wait_cnt++;
    end
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      // New offers during HOLD must be ignored and outputs must not move.
      in_valid = 1'b1; a = $urandom; b = $urandom; signed_mode = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready),  32'd0);
      check("hold_a",     32'(out_a),     32'(e.a));
      check("hold_b",     32'(out_b),     32'(e.b));
      check("hold_eq",    32'(out_eq),    32'(e.eq));
      check("hold_slt",   32'(out_slt),   32'(e.slt));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    check("rst_a",     32'(out_a),     32'd0);
    check("rst_eq",    32'(out_eq),    32'd0);
    check("rst_slt",   32'(out_slt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_txn(8'h35, 8'h35, 1'b0, 0);
    do_txn(8'h80, 8'h01, 1'b0, 0);
    do_txn(8'h80, 8'h01, 1'b1, 0);
    do_txn(8'h12, 8'h13, 1'b0, 0);
    do_txn(8'hFF, 8'h00, 1'b1, 0);
    do_txn(8'hFF, 8'h00, 1'b0, 0);
    do_txn(8'h7F, 8'h80, 1'b1, 5);
    do_txn(8'h00, 8'h00, 1'b1, 1);

    // Reset during the second SCAN cycle drops the transaction.
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    check("midrst_a",     32'(out_a),     32'd0);
    check("midrst_b",     32'(out_b),     32'd0);
    check("midrst_eq",    32'(out_eq),    32'd0);
    check("midrst_slt",   32'(out_slt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_result", 32'(out_valid), 32'd0);
    do_txn(8'h44, 8'h43, 1'b1, 0);

    for (int t = 0; t < 60; t++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      do_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
